// File: rtl/dp_jtag_regs.sv
// JTAG-DP register block: IR, IDCODE/BYPASS/DPACC data registers and the
// single-entry DP access request handshake, all clocked on tck.
module dp_jtag_regs #(
   parameter logic [31:0] IDCODE_VAL = 32'h4BA00477,
   parameter int          IR_W       = 4
) (
   input  logic            tck,
   input  logic            trst,
   input  logic            tlr,
   input  logic            capture_ir,
   input  logic            shift_ir,
   input  logic            update_ir,
   input  logic            capture_dr,
   input  logic            shift_dr,
   input  logic            update_dr,
   input  logic            sel_tdo,
   input  logic            tdi,
   output logic            tdo,
   output logic            req_valid,
   input  logic            req_ready,
   output logic            req_rnw,
   output logic [1:0]      req_addr,
   output logic [31:0]     req_wdata,
   input  logic [31:0]     rsp_rdata,
   input  logic [2:0]      rsp_ack,
   output logic [IR_W-1:0] ir_out
);

   localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(4'b1110);
   localparam logic [IR_W-1:0] IR_DPACC  = IR_W'(4'b1010);
   localparam logic [IR_W-1:0] IR_RESET_SH = IR_W'(1);

   logic [IR_W-1:0] ir_sh_reg;
   logic [IR_W-1:0] ir_out_reg;
   logic [31:0]     dr_id_reg;
   logic [34:0]     dr_dp_reg;
   logic            dr_byp_reg;
   logic            req_valid_reg;
   logic            req_rnw_reg;
   logic [1:0]      req_addr_reg;
   logic [31:0]     req_wdata_reg;

   logic is_idcode;
   logic is_dpacc;
   logic act_cap_ir, act_sh_ir, act_up_ir, any_ir;
   logic act_cap_dr, act_sh_dr, act_up_dr;
   logic [2:0] ack_cap;
   logic dr_tdo;

   // Only one qualifier wins per cycle: capture > shift > update, IR before DR.
   always_comb begin
      is_idcode  = (ir_out_reg == IR_IDCODE);
      is_dpacc   = (ir_out_reg == IR_DPACC);
      act_cap_ir = capture_ir;
      act_sh_ir  = shift_ir & ~capture_ir;
      act_up_ir  = update_ir & ~capture_ir & ~shift_ir;
      any_ir     = capture_ir | shift_ir | update_ir;
      act_cap_dr = capture_dr & ~any_ir;
      act_sh_dr  = shift_dr & ~capture_dr & ~any_ir;
      act_up_dr  = update_dr & ~shift_dr & ~capture_dr & ~any_ir;
      ack_cap    = req_valid_reg ? 3'b001 : rsp_ack;
      if (is_idcode)
         dr_tdo = dr_id_reg[0];
      else if (is_dpacc)
         dr_tdo = dr_dp_reg[0];
      else
         dr_tdo = dr_byp_reg;
   end

   always_ff @(posedge tck) begin
      if (trst) begin
         ir_sh_reg     <= IR_RESET_SH;
         ir_out_reg    <= IR_IDCODE;
         dr_id_reg     <= '0;
         dr_dp_reg     <= '0;
         dr_byp_reg    <= 1'b0;
         req_valid_reg <= 1'b0;
         req_rnw_reg   <= 1'b0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
      end else begin
         if (act_cap_ir)
            ir_sh_reg <= IR_RESET_SH;
         else if (act_sh_ir)
            ir_sh_reg <= {tdi, ir_sh_reg[IR_W-1:1]};

         if (tlr)
            ir_out_reg <= IR_IDCODE;
         else if (act_up_ir)
            ir_out_reg <= ir_sh_reg;

         if (act_cap_dr) begin
            if (is_idcode)
               dr_id_reg <= IDCODE_VAL;
            else if (is_dpacc)
               dr_dp_reg <= {rsp_rdata, ack_cap};
            else
               dr_byp_reg <= 1'b0;
         end else if (act_sh_dr) begin
            if (is_idcode)
               dr_id_reg <= {tdi, dr_id_reg[31:1]};
            else if (is_dpacc)
               dr_dp_reg <= {tdi, dr_dp_reg[34:1]};
            else
               dr_byp_reg <= tdi;
         end

         // A pending request blocks any new DPACC update, even one arriving
         // in the same cycle that the pending one retires.
         if (req_valid_reg) begin
            if (req_ready)
               req_valid_reg <= 1'b0;
         end else if (act_up_dr && is_dpacc) begin
            req_valid_reg <= 1'b1;
            req_rnw_reg   <= dr_dp_reg[0];
            req_addr_reg  <= dr_dp_reg[2:1];
            req_wdata_reg <= dr_dp_reg[34:3];
         end
      end
   end

   assign tdo       = sel_tdo ? ir_sh_reg[0] : dr_tdo;
   assign ir_out    = ir_out_reg;
   assign req_valid = req_valid_reg;
   assign req_rnw   = req_rnw_reg;
   assign req_addr  = req_addr_reg;
   assign req_wdata = req_wdata_reg;

endmodule

// File: tb/tb_dp_jtag_regs.sv
// Directed bench for dp_jtag_regs: IDCODE/IR/BYPASS scans, DPACC request
// handshake, WAIT response, unknown opcode, reset and TLR behaviour.
module tb_dp_jtag_regs;

   logic        tck = 1'b0;
   logic        trst = 1'b0;
   logic        tlr = 1'b0;
   logic        capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
   logic        capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
   logic        sel_tdo = 1'b0;
   logic        tdi = 1'b0;
   logic        tdo;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_rnw;
   logic [1:0]  req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rsp_rdata = 32'h0;
   logic [2:0]  rsp_ack = 3'b0;
   logic [3:0]  ir_out;

   int checks = 0;
   int fails  = 0;
   logic [63:0] dout;

   dp_jtag_regs dut (
      .tck(tck), .trst(trst), .tlr(tlr),
      .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .sel_tdo(sel_tdo), .tdi(tdi), .tdo(tdo),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack), .ir_out(ir_out)
   );

   always #5 tck = ~tck;

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_ir(input logic [3:0] code);
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tdi = code[i];
         tick();
      end
      shift_ir = 1'b0;
      update_ir = 1'b1;
      tick();
      update_ir = 1'b0;
      tdi = 1'b0;
   endtask

   task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dq);
      dq = '0;
      sel_tdo = 1'b0;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < n; i++) begin
         tdi = din[i];
         dq[i] = tdo;
         tick();
      end
      shift_dr = 1'b0;
      tdi = 1'b0;
   endtask

   task automatic pulse_update_dr();
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
   endtask

   initial begin
      // Reset state
      trst = 1'b1;
      tick();
      trst = 1'b0;
      check("rst_ir_out", 64'(ir_out), 64'hE);
      check("rst_req_valid", 64'(req_valid), 64'h0);
      check("rst_req_wdata", 64'(req_wdata), 64'h0);
      sel_tdo = 1'b1;
      #1;
      check("rst_tdo_ir", 64'(tdo), 64'h1);
      sel_tdo = 1'b0;
      #1;
      check("rst_tdo_dr", 64'(tdo), 64'h0);

      // IDCODE read
      scan_dr(32, 64'h0, dout);
      check("idcode", dout, 64'h4BA00477);

      // IR scan with tdo observed from the IR path
      sel_tdo = 1'b1;
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      dout = '0;
      for (int i = 0; i < 4; i++) begin
         tdi = 1'b1;
         dout[i] = tdo;
         tick();
      end
      shift_ir = 1'b0;
      check("ir_scan_tdo", dout, 64'h1);
      update_ir = 1'b1;
      tick();
      update_ir = 1'b0;
      check("ir_out_bypass", 64'(ir_out), 64'hF);
      scan_dr(8, 64'hB2, dout);
      check("bypass_delay", dout, 64'h64);

      // DPACC write
      load_ir(4'b1010);
      check("ir_out_dpacc", 64'(ir_out), 64'hA);
      rsp_rdata = 32'h12345678;
      rsp_ack = 3'b010;
      scan_dr(35, {29'b0, 32'hDEADBEEF, 2'b01, 1'b0}, dout);
      check("dpacc_capture", dout, {29'b0, 32'h12345678, 3'b010});
      check("no_req_before_update", 64'(req_valid), 64'h0);
      pulse_update_dr();
      check("wr_req_valid", 64'(req_valid), 64'h1);
      check("wr_req_addr", 64'(req_addr), 64'h1);
      check("wr_req_rnw", 64'(req_rnw), 64'h0);
      check("wr_req_wdata", 64'(req_wdata), 64'hDEADBEEF);
      tick();
      tick();
      check("wr_hold_valid", 64'(req_valid), 64'h1);

      // WAIT while pending, second update discarded
      scan_dr(35, {29'b0, 32'hCAFEF00D, 2'b10, 1'b1}, dout);
      check("wait_ack", 64'(dout[2:0]), 64'h1);
      check("wait_rdata", 64'(dout[34:3]), 64'h12345678);
      pulse_update_dr();
      check("wait_wdata_kept", 64'(req_wdata), 64'hDEADBEEF);
      check("wait_addr_kept", 64'(req_addr), 64'h1);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("wr_retired", 64'(req_valid), 64'h0);

      // TLR with a request pending: ir_out reset, request untouched
      scan_dr(35, {29'b0, 32'h00000000, 2'b11, 1'b1}, dout);
      pulse_update_dr();
      check("rd_req_valid", 64'(req_valid), 64'h1);
      check("rd_req_rnw", 64'(req_rnw), 64'h1);
      check("rd_req_addr", 64'(req_addr), 64'h3);
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      check("tlr_ir_out", 64'(ir_out), 64'hE);
      check("tlr_req_kept", 64'(req_valid), 64'h1);

      // Retire and new update in the same cycle: new request dropped
      load_ir(4'b1010);
      scan_dr(35, {29'b0, 32'h55AA55AA, 2'b10, 1'b0}, dout);
      req_ready = 1'b1;
      pulse_update_dr();
      req_ready = 1'b0;
      check("same_cycle_retire", 64'(req_valid), 64'h0);
      tick();
      check("same_cycle_dropped", 64'(req_valid), 64'h0);
      check("same_cycle_wdata", 64'(req_wdata), 64'h0);

      // Unknown opcode behaves as BYPASS and never raises a request
      load_ir(4'b0011);
      check("ir_out_unknown", 64'(ir_out), 64'h3);
      scan_dr(8, 64'h5D, dout);
      check("unknown_bypass", dout, 64'hBA);
      pulse_update_dr();
      check("unknown_no_req", 64'(req_valid), 64'h0);

      // Reset during a DPACC shift with a request pending
      load_ir(4'b1010);
      scan_dr(35, {29'b0, 32'h0BADF00D, 2'b01, 1'b0}, dout);
      pulse_update_dr();
      check("mid_pending", 64'(req_valid), 64'h1);
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      tdi = 1'b1;
      tick();
      tick();
      trst = 1'b1;
      tick();
      trst = 1'b0;
      shift_dr = 1'b0;
      tdi = 1'b0;
      check("mid_rst_valid", 64'(req_valid), 64'h0);
      check("mid_rst_ir_out", 64'(ir_out), 64'hE);
      check("mid_rst_wdata", 64'(req_wdata), 64'h0);
      load_ir(4'b1111);
      check("pre_tlr_ir_out", 64'(ir_out), 64'hF);
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      check("post_tlr_ir_out", 64'(ir_out), 64'hE);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dp_jtag_regs.md
DP_JTAG_REGS -- requirements
Module: dp_jtag_regs

Interface
REQ-001 SHALL have parameter IDCODE_VAL, default 32'h4BA00477, meaning the value captured into the IDCODE register.
REQ-002 SHALL have parameter IR_W, default 4, meaning the instruction register width.
REQ-003 SHALL have port tck, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port trst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port tlr, input, 1, TAP is in Test-Logic-Reset.
REQ-006 SHALL have ports capture_ir, shift_ir, update_ir, input, 1 each, IR-phase qualifiers from the TAP controller.
REQ-007 SHALL have ports capture_dr, shift_dr, update_dr, input, 1 each, DR-phase qualifiers from the TAP controller.
REQ-008 SHALL have port sel_tdo, input, 1; 1 selects the IR path, 0 selects the DR path.
REQ-009 SHALL have port tdi, input, 1, serial data in.
REQ-010 SHALL have port tdo, output, 1, serial data out.
REQ-011 SHALL have ports req_valid (output, 1), req_ready (input, 1), req_rnw (output, 1), req_addr (output, 2), req_wdata (output, 32); together these form the DP access request.
REQ-012 SHALL have ports rsp_rdata (input, 32) and rsp_ack (input, 3), the last completed access result.
REQ-013 SHALL have port ir_out, output, IR_W, the current instruction.

Function
REQ-014 SHALL decode instructions as follows: 4'b1110 = IDCODE (32-bit DR), 4'b1010 = DPACC (35-bit DR), 4'b1111 = BYPASS (1-bit DR); every other code SHALL select BYPASS.
REQ-015 SHALL have an IR shift register with these actions:
  - capture_ir: load 4'b0001.
  - shift_ir: load {tdi, ir_sh[IR_W-1:1]}.
  - update_ir: copy ir_sh into ir_out.
REQ-016 SHALL have DR actions for the decoded DR as follows:
  - capture_dr: IDCODE loads IDCODE_VAL; BYPASS loads 0; DPACC loads {rsp_rdata, ack_cap}.
  - shift_dr: right shift, with tdi entering the MSB.
REQ-017 SHALL form ack_cap as 3'b001 (WAIT) if req_valid=1 at capture, else rsp_ack.
REQ-018 SHALL drive tdo combinationally: sel_tdo=1 gives ir_sh[0]; sel_tdo=0 gives bit 0 of the DR selected by ir_out.
REQ-019 SHALL, on update_dr with IR=DPACC and req_valid=0, register the request on that edge:
  - req_rnw = dr[0].
  - req_addr = dr[2:1].
  - req_wdata = dr[34:3].
  - req_valid = 1 from the next cycle.
REQ-020 SHALL hold req_valid and its payload stable until a cycle with req_ready=1, then clear req_valid on that edge.
REQ-021 SHALL, on update_dr with IR=DPACC while req_valid=1, discard the new request and leave the pending payload unchanged.
REQ-022 SHALL, when req_ready=1 and a new update_dr occur in the same cycle with req_valid=1, retire the old request and discard the new one; req_valid SHALL be 0 in the next cycle.
REQ-023 SHALL ignore update_dr with IR other than DPACC, with no effect on the request interface.
REQ-024 SHALL, if several qualifiers are asserted together (illegal), apply the priority capture > shift > update, IR qualifiers before DR qualifiers; only one action SHALL occur per cycle.
REQ-025 SHALL, when tlr=1, load ir_out with IDCODE on the next edge; an in-flight request SHALL be unaffected.
REQ-026 SHALL hold all registers when no qualifier is asserted.

Reset
REQ-027 SHALL, with trst=1 at a rising tck edge, set the following:
  - ir_out = 4'b1110 and ir_sh = 4'b0001.
  - All DR shift registers = 0.
  - req_valid = 0, req_rnw = 0, req_addr = 0, req_wdata = 0.
REQ-028 SHALL give trst priority over tlr and over all qualifiers, including mid-shift and while a request is pending; a pending request is dropped.
REQ-029 SHALL have tdo after reset equal to ir_sh[0] = 1 when sel_tdo=1, and 0 when sel_tdo=0.

Verification
REQ-030 SHALL cover IDCODE read: reset, capture_dr, then 32 shift_dr cycles; tdo LSB-first SHALL equal 32'h4BA00477.
REQ-031 SHALL cover the IR scan: capture_ir, then 4 shifts of tdi=1,1,1,1, then update_ir; tdo SHALL read 1,0,0,0, then ir_out = 4'b1111, and a DR scan SHALL return the tdi value delayed by exactly 1 shift.
REQ-032 SHALL cover a DPACC write: IR=1010, shift 35 bits with rnw=0, addr=2'b01, data=32'hDEADBEEF, then update_dr. Required response:
  - Next cycle: req_valid=1, req_addr=1, req_wdata=32'hDEADBEEF.
  - With req_ready=1 for one cycle, req_valid=0 on the following cycle.
REQ-033 SHALL cover WAIT: with a request pending and req_ready=0, issue capture_dr on DPACC; the low 3 tdo bits SHALL be 0b001; a second update_dr SHALL leave req_wdata unchanged.
REQ-034 SHALL cover the unknown opcode: IR=4'b0011 behaves as BYPASS (1-cycle delay), and update_dr SHALL produce no req_valid.
REQ-035 SHALL cover reset mid-operation: assert trst during a DPACC shift with a request pending; next cycle req_valid=0 and ir_out=4'b1110; tlr=1 after IR=1111 SHALL restore ir_out=4'b1110.
